slot_reel_judge: RTL and testbench
==================================

# slot_reel_judge

Downstream consumer of the slot-game reel tick generator in the clock's game mode. It turns three free-running reel tick signals into three decimal reel digits and stops them one at a time on successive button presses. After the third stop it grades the outcome as jackpot, pair or lose, and keeps a saturating score for the display mux.

## Interface
- REEL_MOD, 10: reel modulus; each digit counts 0..REEL_MOD-1 (legal 2..16).
- JACKPOT_PTS, 10: score added on jackpot.
- PAIR_PTS, 2: score added on pair.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- gameselect  in  1  game mode enable (level, synchronous to clk).
- btn2  in  1  stop/restart button (debounced level, asynchronous to clk).
- gameout1, gameout2, gameout3  in  1 each  reel tick inputs (asynchronous to clk).
- reel1, reel2, reel3  out  4 each  current reel digits.
- spinning  out  3  bit i high while reel i+1 advances.
- win  out  2  00 none/lose, 01 pair, 10 jackpot; valid in RESULT.
- score  out  8  accumulated score, saturating 0..255.

## Operation
- Each of btn2 and gameout1..3 passes through a 2-flop synchronizer and a rising-edge detector (third flop plus compare). All logic after that uses only the resulting one-cycle pulses.
- States:
  - IDLE: all reels frozen, spinning=000.
  - SPIN3: spinning=111.
  - SPIN2: spinning=110.
  - SPIN1: spinning=100.
  - RESULT: spinning=000.
- Transitions:
  - gameselect=0 forces IDLE from any state. Digits, win and score are kept.
  - IDLE with gameselect=1 and btn pulse: go to SPIN3 and clear win to 00.
  - SPIN3 btn pulse: go to SPIN2, reel1 frozen.
  - SPIN2 btn pulse: go to SPIN1, reel2 frozen.
  - SPIN1 btn pulse: go to RESULT, reel3 frozen.
  - RESULT btn pulse: go to SPIN3 and clear win to 00. Digits restart from their held values.
- Reel advance: while its spinning bit is 1, each tick pulse increments the digit. The value REEL_MOD-1 wraps to 0.
- Simultaneous stop and tick for the reel being stopped: stop wins and the tick is discarded, so the digit freezes at its pre-pulse value.
- Grading is done on the edge that enters RESULT, using the final digits:
  - all three equal: win=10, score += JACKPOT_PTS.
  - exactly two equal: win=01, score += PAIR_PTS.
  - none equal: win=00, score -= 1.
- Score saturates at 255 on the upper side and at 0 on the lower side. The arithmetic is done 9 bits wide, then clamped.
- Score changes only on entry to RESULT, exactly once per round.

## Timing
- Reset values:
  - state IDLE.
  - reel1/2/3 = 0.
  - spinning = 000.
  - win = 00.
  - score = 0.
  - All synchronizer flops = 0.
- Asynchronous assertion; outputs take reset values immediately. Release is sampled on the next clk edge.
- Reset asserted mid-round discards the round with no score update.
- Input-to-effect latency: a level rise on btn2 or gameoutN first acts on the 3rd rising clk edge after it. An input must stay high for at least 1 clk period to be seen.
- All outputs are registered. spinning, win, score and the frozen digit all update on the same edge as the state transition.
- Tick inputs with a period of 2 clk periods or less may alias or drop pulses. Upstream must keep ticks slower than 4 clk periods.
- btn held high produces exactly one pulse; a new pulse needs a low of at least 1 clk.

## Test plan
- Reset: assert rst mid-SPIN2 with reel1=7 and score=12 -> all outputs 0, state IDLE, and no ticks counted until a new btn press.
- Wrap and stop order: REEL_MOD=10, run 13 ticks on every reel, then press btn three times between ticks -> digits freeze at 3,3,3 in the order reel1, reel2, reel3; spinning goes 111→110→100→000; win=10; score goes 0→10.
- Pair and lose:
  - digits 4,4,9 -> win=01, score +2.
  - digits 1,2,3 from score 0 -> win=00, score stays 0 (floor).
  - digits 1,2,3 from score 5 -> score 4.
- Simultaneous events: align the btn and gameout2 synchronized pulses in the same cycle while in SPIN2 with reel2=5 -> reel2 stays 5 and reel3 still advances on its next tick.
- Saturation: preload score 250 via repeated jackpots, then one more jackpot -> score=255. A following pair keeps 255.
- Mode exit: drop gameselect in SPIN1 -> IDLE, spinning=000, digits held, score unchanged. Further btn presses are ignored until gameselect returns high.

Source files
------------

// File: rtl/slot_reel_judge.sv
// Slot-game reel judge: synchronizes reel ticks and the stop button, runs three
// decimal reels, stops them in order and grades each round into a saturating score.
module slot_reel_judge #(
  parameter int REEL_MOD    = 10,
  parameter int JACKPOT_PTS = 10,
  parameter int PAIR_PTS    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gameselect,
  input  logic       btn2,
  input  logic       gameout1,
  input  logic       gameout2,
  input  logic       gameout3,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic [3:0] reel3,
  output logic [2:0] spinning,
  output logic [1:0] win,
  output logic [7:0] score
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPIN3  = 3'd1,
    SPIN2  = 3'd2,
    SPIN1  = 3'd3,
    RESULT = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE    = 2'b00;
  localparam logic [1:0] WIN_PAIR    = 2'b01;
  localparam logic [1:0] WIN_JACKPOT = 2'b10;

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    if (d == 4'(REEL_MOD - 1)) next_digit = 4'd0;
    else                       next_digit = d + 4'd1;
  endfunction

  function automatic logic [1:0] grade(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c);
    if ((a == b) && (b == c))                  grade = WIN_JACKPOT;
    else if ((a == b) || (b == c) || (a == c)) grade = WIN_PAIR;
    else                                       grade = WIN_NONE;
  endfunction

  // Bit 8 of the 9-bit result flags overflow on add and underflow on subtract.
  function automatic logic [7:0] update_score(input logic [7:0] s, input logic [1:0] w);
    logic [8:0] sum;
    case (w)
      WIN_JACKPOT: begin
        sum = {1'b0, s} + 9'(JACKPOT_PTS);
        update_score = sum[8] ? 8'd255 : sum[7:0];
      end
      WIN_PAIR: begin
        sum = {1'b0, s} + 9'(PAIR_PTS);
        update_score = sum[8] ? 8'd255 : sum[7:0];
      end
      default: begin
        sum = {1'b0, s} - 9'd1;
        update_score = sum[8] ? 8'd0 : sum[7:0];
      end
    endcase
  endfunction

  // Bit order in the sync chain: {btn2, gameout3, gameout2, gameout1}.
  logic [3:0] sync1_r, sync2_r, sync3_r;
  logic [3:0] pulse_s;
  logic [2:0] tick_s;
  logic       btn_s;

  state_t     state_r, state_nxt_s;
  logic [3:0] reel1_r, reel2_r, reel3_r;
  logic [2:0] spin_r, spin_nxt_s;
  logic [1:0] win_r, win_nxt_s;
  logic [7:0] score_r, score_nxt_s;
  logic [2:0] stop_s;
  logic [2:0] adv_s;

  assign pulse_s = sync2_r & ~sync3_r;
  assign tick_s  = pulse_s[2:0];
  assign btn_s   = pulse_s[3];

  // Two-flop synchronizer plus edge-detect flop for button and reel ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      sync3_r <= 4'b0000;
    end else begin
      sync1_r <= {btn2, gameout3, gameout2, gameout1};
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Round sequencing, stop selection and grading on entry to RESULT.
  always_comb begin
    state_nxt_s = state_r;
    spin_nxt_s  = spin_r;
    win_nxt_s   = win_r;
    score_nxt_s = score_r;
    stop_s      = 3'b000;
    if (!gameselect) begin
      state_nxt_s = IDLE;
      spin_nxt_s  = 3'b000;
    end else begin
      case (state_r)
        IDLE, RESULT: begin
          if (btn_s) begin
            state_nxt_s = SPIN3;
            spin_nxt_s  = 3'b111;
            win_nxt_s   = WIN_NONE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        SPIN3: begin
          if (btn_s) begin
            state_nxt_s = SPIN2;
            spin_nxt_s  = 3'b110;
            stop_s      = 3'b001;
          end else begin
            state_nxt_s = SPIN3;
          end
        end
        SPIN2: begin
          if (btn_s) begin
            state_nxt_s = SPIN1;
            spin_nxt_s  = 3'b100;
            stop_s      = 3'b010;
          end else begin
            state_nxt_s = SPIN2;
          end
        end
        SPIN1: begin
          if (btn_s) begin
            state_nxt_s = RESULT;
            spin_nxt_s  = 3'b000;
            stop_s      = 3'b100;
            win_nxt_s   = grade(reel1_r, reel2_r, reel3_r);
            score_nxt_s = update_score(score_r, grade(reel1_r, reel2_r, reel3_r));
          end else begin
            state_nxt_s = SPIN1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          spin_nxt_s  = 3'b000;
        end
      endcase
    end
  end

  // A stop pulse on the reel being frozen discards a coincident tick.
  assign adv_s = spin_r & tick_s & ~stop_s;

  // State, status outputs and reel digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      spin_r  <= 3'b000;
      win_r   <= 2'b00;
      score_r <= 8'd0;
      reel1_r <= 4'd0;
      reel2_r <= 4'd0;
      reel3_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      spin_r  <= spin_nxt_s;
      win_r   <= win_nxt_s;
      score_r <= score_nxt_s;
      if (adv_s[0]) reel1_r <= next_digit(reel1_r);
      if (adv_s[1]) reel2_r <= next_digit(reel2_r);
      if (adv_s[2]) reel3_r <= next_digit(reel3_r);
    end
  end

  assign reel1    = reel1_r;
  assign reel2    = reel2_r;
  assign reel3    = reel3_r;
  assign spinning = spin_r;
  assign win      = win_r;
  assign score    = score_r;

endmodule

// File: tb/tb_slot_reel_judge.sv
// Scoreboard bench for slot_reel_judge: directed rounds push hand-computed
// snapshots; the monitor compares one whenever spinning changes or a check is requested.
module tb_slot_reel_judge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gameselect = 1'b0;
  logic       btn2 = 1'b0;
  logic       gameout1 = 1'b0, gameout2 = 1'b0, gameout3 = 1'b0;
  logic [3:0] reel1, reel2, reel3;
  logic [2:0] spinning;
  logic [1:0] win;
  logic [7:0] score;

  logic [24:0] exp_q[$];
  logic        chk_req = 1'b0;
  logic        done = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  slot_reel_judge #(.REEL_MOD(10), .JACKPOT_PTS(10), .PAIR_PTS(2)) dut (
    .clk(clk), .rst(rst), .gameselect(gameselect), .btn2(btn2),
    .gameout1(gameout1), .gameout2(gameout2), .gameout3(gameout3),
    .reel1(reel1), .reel2(reel2), .reel3(reel3),
    .spinning(spinning), .win(win), .score(score)
  );

  always #5 clk = ~clk;

  task automatic push(input int r1, input int r2, input int r3,
                      input logic [2:0] sp, input logic [1:0] w, input int sc);
    exp_q.push_back({4'(r1), 4'(r2), 4'(r3), sp, w, 8'(sc)});
  endtask

  // m = {btn2, gameout3, gameout2, gameout1}; high for two cycles, then low.
  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    {btn2, gameout3, gameout2, gameout1} = m;
    repeat (2) @(negedge clk);
    {btn2, gameout3, gameout2, gameout1} = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic press();
    pulse(4'b1000);
  endtask

  task automatic ticks(input logic [2:0] m, input int n);
    for (int i = 0; i < n; i++) pulse({1'b0, m});
  endtask

  task automatic check_now();
    chk_req = ~chk_req;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops and compares on every spinning change or explicit request.
  initial begin
    logic [2:0]  prev_spin;
    logic        prev_req;
    logic [24:0] act, expv;
    wait (rst == 1'b0);
    @(negedge clk);
    prev_spin = spinning;
    prev_req  = chk_req;
    while (!done) begin
      @(negedge clk);
      if (spinning !== prev_spin || chk_req !== prev_req) begin
        act = {reel1, reel2, reel3, spinning, win, score};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output got r=%0d,%0d,%0d spin=%b win=%b score=%0d",
                   reel1, reel2, reel3, spinning, win, score);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            n_bad++;
            $display("FAIL snapshot#%0d got r=%0d,%0d,%0d spin=%b win=%b score=%0d want r=%0d,%0d,%0d spin=%b win=%b score=%0d",
                     n_vec, reel1, reel2, reel3, spinning, win, score,
                     expv[24:21], expv[20:17], expv[16:13], expv[12:10], expv[9:8], expv[7:0]);
          end
        end
        prev_spin = spinning;
        prev_req  = chk_req;
      end
    end
    while (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_output got none want spin=%b win=%b score=%0d",
               expv[12:10], expv[9:8], expv[7:0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    gameselect = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push(0, 0, 0, 3'b000, 2'b00, 0); check_now();

    // Wrap: 13 ticks on every reel, stops in order, jackpot 3,3,3.
    push(0, 0, 0, 3'b111, 2'b00, 0);  press();
    ticks(3'b111, 13);
    push(3, 3, 3, 3'b110, 2'b00, 0);  press();
    push(3, 3, 3, 3'b100, 2'b00, 0);  press();
    push(3, 3, 3, 3'b000, 2'b10, 10); press();

    // Pair 4,4,9.
    push(3, 3, 3, 3'b111, 2'b00, 10); press();
    ticks(3'b111, 1);
    push(4, 4, 4, 3'b110, 2'b00, 10); press();
    push(4, 4, 4, 3'b100, 2'b00, 10); press();
    ticks(3'b100, 5);
    push(4, 4, 9, 3'b000, 2'b01, 12); press();

    // Lose 1,2,3: score 12 -> 11.
    push(4, 4, 9, 3'b111, 2'b00, 12); press();
    ticks(3'b111, 7);
    push(1, 1, 6, 3'b110, 2'b00, 12); press();
    ticks(3'b110, 1);
    push(1, 2, 7, 3'b100, 2'b00, 12); press();
    ticks(3'b100, 6);
    push(1, 2, 3, 3'b000, 2'b00, 11); press();

    // Stop and reel2 tick coincide in SPIN2: reel2 holds 5, reel3 keeps counting.
    push(1, 2, 3, 3'b111, 2'b00, 11); press();
    push(1, 2, 3, 3'b110, 2'b00, 11); press();
    ticks(3'b110, 3);
    push(1, 5, 6, 3'b100, 2'b00, 11); pulse(4'b1010);
    ticks(3'b100, 1);
    push(1, 5, 7, 3'b000, 2'b00, 10); press();

    // Mode exit in SPIN1; presses ignored while gameselect is low.
    push(1, 5, 7, 3'b111, 2'b00, 10); press();
    push(1, 5, 7, 3'b110, 2'b00, 10); press();
    push(1, 5, 7, 3'b100, 2'b00, 10); press();
    push(1, 5, 7, 3'b000, 2'b00, 10);
    @(negedge clk); gameselect = 1'b0;
    repeat (3) @(negedge clk);
    press();
    ticks(3'b111, 2);
    push(1, 5, 7, 3'b000, 2'b00, 10); check_now();
    gameselect = 1'b1;
    push(1, 5, 7, 3'b111, 2'b00, 10); press();

    // Line up 1,1,1, then repeat jackpots up to saturation.
    push(1, 5, 7, 3'b110, 2'b00, 10); press();
    ticks(3'b110, 6);
    push(1, 1, 3, 3'b100, 2'b00, 10); press();
    ticks(3'b100, 8);
    push(1, 1, 1, 3'b000, 2'b10, 20); press();
    for (int k = 0; k < 24; k++) begin
      int s0, s1;
      s0 = 20 + 10 * k;
      s1 = (s0 + 10 > 255) ? 255 : s0 + 10;
      push(1, 1, 1, 3'b111, 2'b00, s0); press();
      push(1, 1, 1, 3'b110, 2'b00, s0); press();
      push(1, 1, 1, 3'b100, 2'b00, s0); press();
      push(1, 1, 1, 3'b000, 2'b10, s1); press();
    end
    // Pair at saturation holds 255.
    push(1, 1, 1, 3'b111, 2'b00, 255); press();
    push(1, 1, 1, 3'b110, 2'b00, 255); press();
    push(1, 1, 1, 3'b100, 2'b00, 255); press();
    ticks(3'b100, 1);
    push(1, 1, 2, 3'b000, 2'b01, 255); press();

    // Reset mid-SPIN2 clears everything; IDLE ticks are not counted.
    push(1, 1, 2, 3'b111, 2'b00, 255); press();
    push(1, 1, 2, 3'b110, 2'b00, 255); press();
    ticks(3'b110, 1);
    push(0, 0, 0, 3'b000, 2'b00, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    ticks(3'b111, 3);
    push(0, 0, 0, 3'b000, 2'b00, 0); check_now();

    // Lose at score 0 stays at 0.
    push(0, 0, 0, 3'b111, 2'b00, 0); press();
    ticks(3'b111, 1);
    push(1, 1, 1, 3'b110, 2'b00, 0); press();
    ticks(3'b110, 1);
    push(1, 2, 2, 3'b100, 2'b00, 0); press();
    ticks(3'b100, 1);
    push(1, 2, 3, 3'b000, 2'b00, 0); press();

    repeat (5) @(negedge clk);
    done = 1'b1;
  end

endmodule
